// File: rtl/alu_arb_pkg.sv
// Shared encodings and defaults for the two-requester ALU arbiter.
// The ALU itself owns the arithmetic; these values only describe its interface.
package alu_arb_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int FLAG_WIDTH_DEF = 2;
   localparam int OF_BIT         = 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer remembers the most recent winner
// and only moves when a grant is actually taken.
module rr_arb2 #(
   parameter int INIT_PRIO = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // Seeded as if the other requester won last, so INIT_PRIO takes the first tie.
   localparam logic LAST_INIT = (INIT_PRIO == 0) ? 1'b1 : 1'b0;

   logic last;

   always_ff @(posedge clk) begin
      if (!reset) begin
         last <= LAST_INIT;
      end else if (advance && (grant != 2'b00)) begin
         last <= grant[1];
      end
   end

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute stage (requester 0) and the PC path
// (requester 1): registered operands out, registered result/flags back.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int FLAG_WIDTH = FLAG_WIDTH_DEF,
   parameter int INIT_PRIO  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  op0,
   input  logic [DATA_WIDTH-1:0] a0,
   input  logic [DATA_WIDTH-1:0] b0,
   input  logic                  req1,
   input  logic                  op1,
   input  logic [DATA_WIDTH-1:0] a1,
   input  logic [DATA_WIDTH-1:0] b1,
   output logic                  ack0,
   output logic                  ack1,
   output logic                  done0,
   output logic                  done1,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic [FLAG_WIDTH-1:0] rsp_flags,
   output logic                  busy,
   output logic                  alu_op,
   output logic [DATA_WIDTH-1:0] alu_operand1,
   output logic [DATA_WIDTH-1:0] alu_operand2,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic [FLAG_WIDTH-1:0] alu_flags
);

   arb_state_t            state, state_n;
   logic [1:0]            grant;
   logic                  sel, sel_n;
   logic                  ack0_n, ack1_n, done0_n, done1_n;
   logic                  op_n;
   logic [DATA_WIDTH-1:0] opd1_n, opd2_n, res_n;
   logic [FLAG_WIDTH-1:0] flg_n;

   rr_arb2 #(.INIT_PRIO(INIT_PRIO)) u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     ({req1, req0}),
      .advance (state == IDLE),
      .grant   (grant)
   );

   assign busy = (state != IDLE);

   always_comb begin
      state_n = state;
      sel_n   = sel;
      ack0_n  = 1'b0;
      ack1_n  = 1'b0;
      done0_n = 1'b0;
      done1_n = 1'b0;
      op_n    = alu_op;
      opd1_n  = alu_operand1;
      opd2_n  = alu_operand2;
      res_n   = rsp_result;
      flg_n   = rsp_flags;
      case (state)
         IDLE: begin
            if (grant[0]) begin
               ack0_n  = 1'b1;
               sel_n   = 1'b0;
               op_n    = op0;
               opd1_n  = a0;
               opd2_n  = b0;
               state_n = EXEC;
            end else if (grant[1]) begin
               ack1_n  = 1'b1;
               sel_n   = 1'b1;
               op_n    = op1;
               opd1_n  = a1;
               opd2_n  = b1;
               state_n = EXEC;
            end
         end
         EXEC: begin
            // ALU inputs have been stable for a full cycle; take its answer as-is.
            res_n   = alu_result;
            flg_n   = alu_flags;
            done0_n = ~sel;
            done1_n = sel;
            state_n = RESP;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         sel          <= 1'b0;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         done0        <= 1'b0;
         done1        <= 1'b0;
         alu_op       <= 1'b0;
         alu_operand1 <= '0;
         alu_operand2 <= '0;
         rsp_result   <= '0;
         rsp_flags    <= '0;
      end else begin
         state        <= state_n;
         sel          <= sel_n;
         ack0         <= ack0_n;
         ack1         <= ack1_n;
         done0        <= done0_n;
         done1        <= done1_n;
         alu_op       <= op_n;
         alu_operand1 <= opd1_n;
         alu_operand2 <= opd2_n;
         rsp_result   <= res_n;
         rsp_flags    <= flg_n;
      end
   end

endmodule
